channel_unpack: RTL and testbench



---
 rtl/channel_unpack_if.sv | 24 ++
 rtl/channel_unpack.sv | 65 ++++++
 tb/tb_channel_unpack.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/channel_unpack_if.sv
// channel_unpack_if: wide-in / narrow-out set/get stream bundle.
// slave = unpacker side, master = producer/consumer side.
interface channel_unpack_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);
  logic [WIDTH*COUNT-1:0] in_dat;
  logic                   in_set;
  logic                   in_get;
  logic [WIDTH-1:0]       out_dat;
  logic                   out_set;
  logic                   out_last;
  logic                   out_get;

  modport master (
    output in_dat, in_set, out_get,
    input  in_get, out_dat, out_set, out_last
  );

  modport slave (
    input  in_dat, in_set, out_get,
    output in_get, out_dat, out_set, out_last
  );
endinterface

// File: rtl/channel_unpack.sv
// channel_unpack: splits one WIDTH*COUNT word into COUNT slices, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave: in_* wide, out_* narrow).
module channel_unpack #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  channel_unpack_if.slave  bus
);
  localparam int CW = $clog2(COUNT);
  localparam int SW = WIDTH * (COUNT - 1);

  logic [SW-1:0]    r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dat;
  logic             r_set;
  logic             r_last;

  logic w_free;
  logic w_load;
  logic w_accept;

  // Output slot is empty or emptying this edge.
  assign w_free   = !r_set || bus.out_get;
  assign w_load   = w_free && (r_cnt != '0);
  assign w_accept = w_free && (r_cnt == '0) && bus.in_set;

  assign bus.in_get   = !rst && (r_cnt == '0) && w_free;
  assign bus.out_dat  = r_dat;
  assign bus.out_set  = r_set;
  assign bus.out_last = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_dat  <= '0;
      r_set  <= 1'b0;
      r_last <= 1'b0;
    end else if (w_free) begin
      unique case (1'b1)
        w_load: begin
          r_dat  <= r_sh[WIDTH-1:0];
          r_sh   <= r_sh >> WIDTH;
          r_cnt  <= r_cnt - CW'(1);
          r_set  <= 1'b1;
          r_last <= (r_cnt == CW'(1));
        end
        w_accept: begin
          r_dat  <= bus.in_dat[WIDTH-1:0];
          r_sh   <= bus.in_dat[WIDTH*COUNT-1:WIDTH];
          r_cnt  <= CW'(COUNT - 1);
          r_set  <= 1'b1;
          r_last <= 1'b0;
        end
        default: begin
          // Nothing to present; out_dat keeps its last value.
          r_set  <= 1'b0;
          r_last <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_channel_unpack.sv
// tb_channel_unpack: directed and random checks of channel_unpack
// against a queue-of-slices reference model.
module tb_channel_unpack;
  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  channel_unpack_if #(.WIDTH(W), .COUNT(C)) bus ();

  channel_unpack #(.WIDTH(W), .COUNT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } ent_t;

  // Slices accepted but not yet taken by the consumer, head = presented.
  ent_t q[$];
  logic p_in_get;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input logic s, input logic [31:0] d,
                     input logic g, input logic r);
    logic exp_get;
    rst         = r;
    bus.in_set  = s;
    bus.in_dat  = d;
    bus.out_get = g;
    #1;
    // A new word fits only if nothing beyond the presented slice remains
    // and the presented slice (if any) leaves this edge.
    exp_get  = !r && (q.size() == 0 || (q.size() == 1 && g));
    p_in_get = bus.in_get;
    chk("in_get", bus.in_get, exp_get);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
    end else begin
      if (q.size() > 0 && g) void'(q.pop_front());
      if (exp_get && s)
        for (int k = 0; k < C; k++)
          q.push_back('{d: d[k*W +: W], l: (k == C - 1)});
    end
    chk("out_set", bus.out_set, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_dat", bus.out_dat, q[0].d);
      chk("out_last", bus.out_last, q[0].l);
    end
    if (r) begin
      chk("rst_dat", bus.out_dat, 0);
      chk("rst_last", bus.out_last, 0);
    end
  endtask

  initial begin
    bus.in_set  = 1'b0;
    bus.in_dat  = '0;
    bus.out_get = 1'b0;
    @(posedge clk);
    #1;

    // reset
    cyc(1'b1, 32'h44332211, 1'b1, 1'b1);
    chk("rst_in_get", p_in_get, 0);
    chk("rst_set", bus.out_set, 0);

    // single word
    cyc(1'b1, 32'h44332211, 1'b1, 1'b0);
    chk("single_acc", p_in_get, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("single_dat", bus.out_dat, 17 * (k + 1));
      chk("single_last", bus.out_last, k == 3);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("single_end", bus.out_set, 0);

    // back-to-back
    for (int k = 0; k < 9; k++) begin
      cyc(k < 8, (k < 4) ? 32'h44332211 : 32'h88776655, 1'b1, 1'b0);
      chk("b2b_get", p_in_get, k == 0 || k == 4 || k == 8);
      if (k < 8) begin
        chk("b2b_set", bus.out_set, 1);
        chk("b2b_dat", bus.out_dat, 17 * (k + 1));
        chk("b2b_last", bus.out_last, k == 3 || k == 7);
      end else begin
        chk("b2b_end", bus.out_set, 0);
      end
    end

    // backpressure on 0x22
    cyc(1'b1, 32'h44332211, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_first", bus.out_dat, 32'h22);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h99999999, 1'b0, 1'b0);
      chk("bp_hold_dat", bus.out_dat, 32'h22);
      chk("bp_hold_set", bus.out_set, 1);
      chk("bp_in_get", p_in_get, 0);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_33", bus.out_dat, 32'h33);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_44", bus.out_dat, 32'h44);
    chk("bp_last", bus.out_last, 1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_end", bus.out_set, 0);

    // idle gap
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, $urandom, 1'b1, 1'b0);
      chk("idle_set", bus.out_set, 0);
      chk("idle_in_get", p_in_get, 1);
    end

    // reset mid-word
    cyc(1'b1, 32'h44332211, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid_22", bus.out_dat, 32'h22);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("mid_rst_set", bus.out_set, 0);
    chk("mid_rst_last", bus.out_last, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(k == 0, 32'hDDCCBBAA, 1'b1, 1'b0);
      if (k == 0) chk("mid_cnt0", p_in_get, 1);
      chk("mid_new", bus.out_dat, 32'hAA + 17 * k);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("mid_end", bus.out_set, 0);

    // random stress
    for (int n = 0; n < 10000; n++)
      cyc($urandom_range(0, 3) != 0, $urandom,
          $urandom_range(0, 3) != 0, 1'b0);
    for (int n = 0; n < 8; n++)
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_set", bus.out_set, 0);
    chk("drain_q", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
